// File: rtl/jt51_acc_sched_pkg.sv
// Shared definitions for the jt51 accumulator slot scheduler:
// slot positions of the group-entry strobes, group encodings,
// configuration field widths and the word carried down the delay line.
package jt51_acc_sched_pkg;

    localparam logic [4:0] SLOT_M1   = 5'd0;
    localparam logic [4:0] SLOT_M2   = 5'd8;
    localparam logic [4:0] SLOT_C1   = 5'd16;
    localparam logic [4:0] SLOT_C2   = 5'd24;
    localparam logic [4:0] SLOT_OP31 = 5'd31;

    // Group is slot[4:3]; channel is slot[2:0].
    typedef enum logic [1:0] {
        GRP_M1 = 2'd0,
        GRP_M2 = 2'd1,
        GRP_C1 = 2'd2,
        GRP_C2 = 2'd3
    } grp_e;

    localparam int RL_W   = 2;
    localparam int CON_W  = 3;
    localparam int CH_W   = 3;
    localparam int NUM_CH = 8;

    typedef struct packed {
        logic             m1;
        logic             m2;
        logic             c1;
        logic             c2;
        logic             op31;
        logic [RL_W-1:0]  rl;
        logic [CON_W-1:0] con;
    } acc_word_t;

    localparam int WORD_W = $bits(acc_word_t);

    // Raw strobes for a slot, bundled with that slot's channel config.
    function automatic acc_word_t decode_slot(input logic [4:0] s,
                                              input logic [RL_W-1:0] rl,
                                              input logic [CON_W-1:0] con);
        acc_word_t w;
        w.m1   = (s == SLOT_M1);
        w.m2   = (s == SLOT_M2);
        w.c1   = (s == SLOT_C1);
        w.c2   = (s == SLOT_C2);
        w.op31 = (s == SLOT_OP31);
        w.rl   = rl;
        w.con  = con;
        return w;
    endfunction

endpackage

// File: rtl/jt51_acc_sched_dly.sv
// jt51_sched_dly: generic cen-gated delay line of STAGES steps.
// STAGES=0 degenerates to a plain wire. Cleared by synchronous active-low reset.
module jt51_sched_dly #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, cen};
            assign dout = din;
        end else begin : g_line
            logic [STAGES-1:0][WIDTH-1:0] line_q, line_d;

            // Shift one position per cen step, holding otherwise
            always_comb begin
                line_d = line_q;
                if (cen) begin
                    line_d[0] = din;
                    for (int i = 1; i < STAGES; i++) begin
                        line_d[i] = line_q[i-1];
                    end
                end
            end

            // Delay line storage with reset clear
            always_ff @(posedge clk) begin
                if (!rst_n) line_q <= '0;
                else        line_q <= line_d;
            end

            assign dout = line_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/jt51_acc_sched.sv
// jt51_acc_sched: 32-slot operator frame scheduler for the output accumulator.
// Generates group-entry and slot-31 strobes aligned to the accumulator stage
// and supplies per-channel rl/con from a double-buffered config bank.
// Optional feature macro: JT51_ACC_MUTE_EN adds a per-channel mute mask.
module jt51_acc_sched
    import jt51_acc_sched_pkg::*;
#(
    parameter int ACC_DLY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [RL_W-1:0]  cfg_rl,
    input  logic [CON_W-1:0] cfg_con,
`ifdef JT51_ACC_MUTE_EN
    input  logic [NUM_CH-1:0] mute,
`endif
    output logic [4:0]       slot,
    output logic             m1_enters,
    output logic             m2_enters,
    output logic             c1_enters,
    output logic             c2_enters,
    output logic             op31_acc,
    output logic [RL_W-1:0]  rl_I,
    output logic [CON_W-1:0] con_I,
    output logic             sample_stb
);

    logic [4:0]                     slot_q, slot_d;
    logic [NUM_CH-1:0][RL_W-1:0]    stg_rl_q, stg_rl_d, act_rl_q, act_rl_d;
    logic [NUM_CH-1:0][CON_W-1:0]   stg_con_q, stg_con_d, act_con_q, act_con_d;
`ifdef JT51_ACC_MUTE_EN
    logic [NUM_CH-1:0]              act_mute_q, act_mute_d;
`endif
    acc_word_t                      raw_word, out_q, out_d;
    logic [WORD_W-1:0]              raw_bits, dly_bits;
    logic                           sample_stb_q, sample_stb_d;
    logic [RL_W-1:0]                raw_rl;

    // Slot advance, staging writes and frame commit (write on commit edge bypasses)
    always_comb begin
        slot_d    = slot_q;
        stg_rl_d  = stg_rl_q;
        stg_con_d = stg_con_q;
        act_rl_d  = act_rl_q;
        act_con_d = act_con_q;
`ifdef JT51_ACC_MUTE_EN
        act_mute_d = act_mute_q;
`endif
        if (cfg_we) begin
            stg_rl_d[cfg_ch]  = cfg_rl;
            stg_con_d[cfg_ch] = cfg_con;
        end
        if (cen) begin
            slot_d = slot_q + 5'd1;
            if (slot_q == SLOT_OP31) begin
                act_rl_d  = stg_rl_d;
                act_con_d = stg_con_d;
`ifdef JT51_ACC_MUTE_EN
                act_mute_d = mute;
`endif
            end
        end
    end

    // Raw strobes and active-bank config for the channel at the current slot
    always_comb begin
        raw_rl = act_rl_q[slot_q[2:0]];
`ifdef JT51_ACC_MUTE_EN
        if (act_mute_q[slot_q[2:0]]) raw_rl = '0;
`endif
        raw_word = decode_slot(slot_q, raw_rl, act_con_q[slot_q[2:0]]);
    end

    assign raw_bits = raw_word;

    jt51_sched_dly #(
        .WIDTH  (WORD_W),
        .STAGES (ACC_DLY)
    ) u_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .din    (raw_bits),
        .dout   (dly_bits)
    );

    // Output register loads on cen; sample strobe lasts a single clk only
    always_comb begin
        out_d        = out_q;
        sample_stb_d = 1'b0;
        if (cen) begin
            out_d        = acc_word_t'(dly_bits);
            sample_stb_d = out_d.c1;
        end
    end

    // State registers; reset dominates cen and cfg_we
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q       <= '0;
            stg_rl_q     <= '0;
            stg_con_q    <= '0;
            act_rl_q     <= '0;
            act_con_q    <= '0;
`ifdef JT51_ACC_MUTE_EN
            act_mute_q   <= '0;
`endif
            out_q        <= '0;
            sample_stb_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            stg_rl_q     <= stg_rl_d;
            stg_con_q    <= stg_con_d;
            act_rl_q     <= act_rl_d;
            act_con_q    <= act_con_d;
`ifdef JT51_ACC_MUTE_EN
            act_mute_q   <= act_mute_d;
`endif
            out_q        <= out_d;
            sample_stb_q <= sample_stb_d;
        end
    end

    assign slot       = slot_q;
    assign m1_enters  = out_q.m1;
    assign m2_enters  = out_q.m2;
    assign c1_enters  = out_q.c1;
    assign c2_enters  = out_q.c2;
    assign op31_acc   = out_q.op31;
    assign rl_I       = out_q.rl;
    assign con_I      = out_q.con;
    assign sample_stb = sample_stb_q;

endmodule

// File: tb/tb_jt51_acc_sched.sv
// Testbench for jt51_acc_sched (ACC_DLY=2). Reference model tracks cen steps
// since reset and a list of per-frame committed config snapshots; the expected
// output after n steps is the slot (n-ACC_DLY-1) decoded with its frame's config.
module tb_jt51_acc_sched;

    localparam int ACC_DLY = 2;
    localparam int LAT     = ACC_DLY + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [1:0] cfg_rl = '0;
    logic [2:0] cfg_con = '0;
`ifdef JT51_ACC_MUTE_EN
    logic [7:0] mute = '0;
`endif
    logic [4:0] slot;
    logic       m1_enters, m2_enters, c1_enters, c2_enters, op31_acc, sample_stb;
    logic [1:0] rl_I;
    logic [2:0] con_I;

    jt51_acc_sched #(.ACC_DLY(ACC_DLY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_rl     (cfg_rl),
        .cfg_con    (cfg_con),
`ifdef JT51_ACC_MUTE_EN
        .mute       (mute),
`endif
        .slot       (slot),
        .m1_enters  (m1_enters),
        .m2_enters  (m2_enters),
        .c1_enters  (c1_enters),
        .c2_enters  (c2_enters),
        .op31_acc   (op31_acc),
        .rl_I       (rl_I),
        .con_I      (con_I),
        .sample_stb (sample_stb)
    );

    always #5 clk = ~clk;

    typedef logic [7:0][1:0] rlb_t;
    typedef logic [7:0][2:0] conb_t;

    int    n;
    logic  last_cen;
    rlb_t  stg_rl;
    conb_t stg_con;
    rlb_t  fr_rl[$];
    conb_t fr_con[$];
`ifdef JT51_ACC_MUTE_EN
    logic [7:0] fr_mute[$];
`endif
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [15:0] exp_word();
        int t;
        logic [4:0] s;
        logic [2:0] ch;
        logic [1:0] rl;
        logic [2:0] con;
        logic [4:0] stb;
        stb = '0; rl = '0; con = '0;
        if (n >= LAT) begin
            t   = n - LAT;
            s   = 5'(t % 32);
            ch  = s[2:0];
            rl  = fr_rl[t/32][ch];
            con = fr_con[t/32][ch];
`ifdef JT51_ACC_MUTE_EN
            if (fr_mute[t/32][ch]) rl = '0;
`endif
            stb = {s == 5'd0, s == 5'd8, s == 5'd16, s == 5'd24, s == 5'd31};
        end
        return {5'(n % 32), stb, rl, con, last_cen & stb[2]};
    endfunction

    function automatic logic [15:0] obs_word();
        return {slot, m1_enters, m2_enters, c1_enters, c2_enters, op31_acc,
                rl_I, con_I, sample_stb};
    endfunction

    task automatic model_reset();
        n = 0; last_cen = 1'b0; stg_rl = '0; stg_con = '0;
        fr_rl = {}; fr_con = {};
        fr_rl.push_back('0); fr_con.push_back('0);
`ifdef JT51_ACC_MUTE_EN
        fr_mute = {}; fr_mute.push_back('0);
`endif
    endtask

    // Called at a negedge; drives one clk edge and updates the model.
    task automatic step(input logic c, input logic we, input logic [2:0] ch,
                        input logic [1:0] rl, input logic [2:0] con);
        cen = c; cfg_we = we; cfg_ch = ch; cfg_rl = rl; cfg_con = con;
        @(posedge clk);
        if (we) begin stg_rl[ch] = rl; stg_con[ch] = con; end
        if (c) begin
            if (n % 32 == 31) begin
                fr_rl.push_back(stg_rl); fr_con.push_back(stg_con);
`ifdef JT51_ACC_MUTE_EN
                fr_mute.push_back(mute);
`endif
            end
            n++;
        end
        last_cen = c;
        @(negedge clk);
        cen = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; cen = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd3; cfg_rl = 2'd3; cfg_con = 3'd5;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; cen = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (obs_word() !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", obs_word(), 16'h0000);
        end
    endtask

    task automatic test_frame_timing();
        int f_m1 = -1, f_m2 = -1, f_c1 = -1, f_c2 = -1, f_op = -1, s_m1 = -1;
        apply_reset();
        for (int k = 1; k <= 70; k++) begin
            step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
            vectors++;
            if (obs_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL timing_model n=%0d got=%h exp=%h", n, obs_word(), exp_word());
            end
            if (m1_enters && f_m1 >= 0 && s_m1 < 0) s_m1 = k;
            if (m1_enters && f_m1 < 0) f_m1 = k;
            if (m2_enters && f_m2 < 0) f_m2 = k;
            if (c1_enters && f_c1 < 0) f_c1 = k;
            if (c2_enters && f_c2 < 0) f_c2 = k;
            if (op31_acc && f_op < 0) f_op = k;
        end
        vectors += 6;
        if (f_m1 !== 3)  begin miscompares++; $display("FAIL first_m1 got=%0d exp=3", f_m1); end
        if (f_m2 !== 11) begin miscompares++; $display("FAIL first_m2 got=%0d exp=11", f_m2); end
        if (f_c1 !== 19) begin miscompares++; $display("FAIL first_c1 got=%0d exp=19", f_c1); end
        if (f_c2 !== 27) begin miscompares++; $display("FAIL first_c2 got=%0d exp=27", f_c2); end
        if (f_op !== 34) begin miscompares++; $display("FAIL first_op31 got=%0d exp=34", f_op); end
        if (s_m1 !== 35) begin miscompares++; $display("FAIL second_m1 got=%0d exp=35", s_m1); end
    endtask

    task automatic test_sparse_cen();
        int m1_rises = 0, m1_rise_at = -1, m2_rise_at = -1, m1_w = 0;
        int ss_hi = 0, ss_rises = 0, c1_rises = 0;
        logic pm1 = 1'b0, pm2 = 1'b0, pss = 1'b0, pc1 = 1'b0;
        apply_reset();
        for (int k = 0; k < 240; k++) begin
            step(k % 3 == 0, 1'b0, 3'd0, 2'd0, 3'd0);
            vectors++;
            if (obs_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL sparse_model n=%0d got=%h exp=%h", n, obs_word(), exp_word());
            end
            if (m1_enters && !pm1) begin m1_rises++; if (m1_rises == 1) m1_rise_at = k; end
            if (m1_enters && m1_rises == 1) m1_w++;
            if (m2_enters && !pm2 && m2_rise_at < 0) m2_rise_at = k;
            if (sample_stb) ss_hi++;
            if (sample_stb && !pss) ss_rises++;
            if (c1_enters && !pc1) c1_rises++;
            pm1 = m1_enters; pm2 = m2_enters; pss = sample_stb; pc1 = c1_enters;
        end
        vectors += 4;
        if (m2_rise_at - m1_rise_at !== 24) begin
            miscompares++; $display("FAIL sparse_spacing got=%0d exp=24", m2_rise_at - m1_rise_at);
        end
        if (m1_w !== 3) begin miscompares++; $display("FAIL sparse_width got=%0d exp=3", m1_w); end
        if (ss_hi !== ss_rises) begin
            miscompares++; $display("FAIL sstb_width high_cycles=%0d pulses=%0d", ss_hi, ss_rises);
        end
        if (ss_rises !== c1_rises || c1_rises == 0) begin
            miscompares++; $display("FAIL sstb_count got=%0d exp=%0d", ss_rises, c1_rises);
        end
    endtask

    task automatic test_cfg_write();
        int t;
        apply_reset();
        while (n < 10) step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
        step(1'b1, 1'b1, 3'd5, 2'd3, 3'd7);
        while (n < 64 + LAT) begin
            step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
            vectors++;
            if (obs_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL cfgw_model n=%0d got=%h exp=%h", n, obs_word(), exp_word());
            end
            t = n - LAT;
            if (t >= 0 && t % 8 == 5) begin
                vectors++;
                if ({rl_I, con_I} !== ((t / 32 == 0) ? 5'b00_000 : 5'b11_111)) begin
                    miscompares++;
                    $display("FAIL cfgw_ch5 t=%0d got=%b exp=%b", t, {rl_I, con_I},
                             (t / 32 == 0) ? 5'b00_000 : 5'b11_111);
                end
            end
        end
    endtask

    task automatic test_commit_bypass();
        int t;
        apply_reset();
        while (n < 31) step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
        step(1'b1, 1'b1, 3'd2, 2'd0, 3'd4);
        while (n < 64 + LAT) begin
            step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
            vectors++;
            if (obs_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL bypass_model n=%0d got=%h exp=%h", n, obs_word(), exp_word());
            end
            t = n - LAT;
            if (t >= 32 && t % 8 == 2) begin
                vectors++;
                if (con_I !== 3'd4) begin
                    miscompares++; $display("FAIL bypass_ch2 t=%0d got=%0d exp=4", t, con_I);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int seen = -1;
        apply_reset();
        step(1'b1, 1'b1, 3'd0, 2'd3, 3'd1);
        while (n < 52) step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
        apply_reset();
        vectors++;
        if (obs_word() !== 16'h0000) begin
            miscompares++; $display("FAIL midrst_zero got=%h exp=%h", obs_word(), 16'h0000);
        end
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
            vectors++;
            if (obs_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL midrst_model n=%0d got=%h exp=%h", n, obs_word(), exp_word());
            end
            if (m1_enters && seen < 0) seen = k;
            if ((k - LAT) % 8 == 0 && k >= LAT) begin
                vectors++;
                if ({rl_I, con_I} !== 5'b0) begin
                    miscompares++; $display("FAIL midrst_cfg k=%0d got=%b exp=00000", k, {rl_I, con_I});
                end
            end
        end
        vectors++;
        if (seen !== LAT) begin miscompares++; $display("FAIL midrst_m1 got=%0d exp=%0d", seen, LAT); end
    endtask

    task automatic test_mute();
        int t;
        logic [1:0] exp_ch0;
        apply_reset();
`ifdef JT51_ACC_MUTE_EN
        mute = 8'h01;
        exp_ch0 = 2'd0;
`else
        exp_ch0 = 2'd3;
`endif
        step(1'b1, 1'b1, 3'd0, 2'd3, 3'd2);
        step(1'b1, 1'b1, 3'd1, 2'd3, 3'd3);
        while (n < 64 + LAT) begin
            step(1'b1, 1'b0, 3'd0, 2'd0, 3'd0);
            vectors++;
            if (obs_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL mute_model n=%0d got=%h exp=%h", n, obs_word(), exp_word());
            end
            t = n - LAT;
            if (t >= 32 && t % 8 == 0) begin
                vectors++;
                if (rl_I !== exp_ch0) begin
                    miscompares++; $display("FAIL mute_ch0 t=%0d got=%0d exp=%0d", t, rl_I, exp_ch0);
                end
            end
            if (t >= 32 && t % 8 == 1) begin
                vectors++;
                if (rl_I !== 2'd3) begin
                    miscompares++; $display("FAIL mute_ch1 t=%0d got=%0d exp=3", t, rl_I);
                end
            end
        end
`ifdef JT51_ACC_MUTE_EN
        mute = 8'h00;
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 1500; k++) begin
`ifdef JT51_ACC_MUTE_EN
            if ($urandom_range(0, 15) == 0) mute = 8'($urandom);
`endif
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 3'($urandom), 2'($urandom), 3'($urandom));
            vectors++;
            if (obs_word() !== exp_word()) begin
                miscompares++;
                $display("FAIL random_model n=%0d got=%h exp=%h", n, obs_word(), exp_word());
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_frame_timing();
        test_sparse_cen();
        test_cfg_write();
        test_commit_bypass();
        test_mid_reset();
        test_mute();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
